// File: rtl/wb_tag_pipeline_if.sv
// wb_tag_pipeline_if
//   Bundles the decode-side inputs and the ID/EX, EX/MEM, MEM/WB tag outputs
//   of the destination-tag pipeline.
//   master : decode/forwarding side (drives decode fields, reads tags/stall)
//   slave  : the tag pipeline itself
//   Decode inputs : IF_ID_Valid, IF_ID_RegisterRs/Rt/Rd, ID_RegWrite,
//                   ID_MemRead, ID_RegDst, ID_Link, ID_UsesRt, Flush
//   Tag outputs   : ID_EX_*, EX_MEM_*, MEM_WB_*, Stall, StallCount
interface wb_tag_pipeline_if #(
    parameter int CNT_W = 16
);
    logic             IF_ID_Valid;
    logic [4:0]       IF_ID_RegisterRs;
    logic [4:0]       IF_ID_RegisterRt;
    logic [4:0]       IF_ID_RegisterRd;
    logic             ID_RegWrite;
    logic             ID_MemRead;
    logic             ID_RegDst;
    logic             ID_Link;
    logic             ID_UsesRt;
    logic             Flush;

    logic [4:0]       ID_EX_RegisterRs;
    logic [4:0]       ID_EX_RegisterRt;
    logic             ID_EX_RegWrite;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic             EX_MEM_RegWrite;
    logic             EX_MEM_MemRead;
    logic [4:0]       EX_MEM_RegisterRd;
    logic             MEM_WB_RegWrite;
    logic [4:0]       MEM_WB_RegisterRd;
    logic             Stall;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output IF_ID_Valid, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
               ID_RegWrite, ID_MemRead, ID_RegDst, ID_Link, ID_UsesRt, Flush,
        input  ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegWrite, ID_EX_MemRead,
               ID_EX_RegisterRd, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_RegisterRd,
               MEM_WB_RegWrite, MEM_WB_RegisterRd, Stall, StallCount
    );

    modport slave (
        input  IF_ID_Valid, IF_ID_RegisterRs, IF_ID_RegisterRt, IF_ID_RegisterRd,
               ID_RegWrite, ID_MemRead, ID_RegDst, ID_Link, ID_UsesRt, Flush,
        output ID_EX_RegisterRs, ID_EX_RegisterRt, ID_EX_RegWrite, ID_EX_MemRead,
               ID_EX_RegisterRd, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_RegisterRd,
               MEM_WB_RegWrite, MEM_WB_RegisterRd, Stall, StallCount
    );
endinterface

// File: rtl/wb_tag_pipeline.sv
// wb_tag_pipeline
//   Destination-tag pipeline and load-use hazard detector. Captures the
//   decoded source/destination register numbers into ID/EX, carries the
//   destination tag through EX/MEM and MEM/WB, and raises a combinational
//   Stall when a load in EX feeds the instruction in decode.
//   clk   : pipeline clock, rising edge
//   reset : synchronous active-high, clears every stage and the counter
//   bus   : wb_tag_pipeline_if.slave (decode inputs, tag outputs, Stall,
//           StallCount)
module wb_tag_pipeline #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    wb_tag_pipeline_if.slave bus
);

    logic [4:0]       id_ex_rs;
    logic [4:0]       id_ex_rt;
    logic [4:0]       id_ex_rd;
    logic             id_ex_rw;
    logic             id_ex_mr;
    logic [4:0]       ex_mem_rd;
    logic             ex_mem_rw;
    logic             ex_mem_mr;
    logic [4:0]       mem_wb_rd;
    logic             mem_wb_rw;
    logic [CNT_W-1:0] stall_count;

    logic             stall;
    logic             bubble;
    logic [4:0]       dec_dest;

    // Destination tag of the decoded instruction. A non-writing instruction
    // carries tag 0 so the forwarding unit can treat 0 as "no write".
    function automatic logic [4:0] dest_sel(
        input logic       regwrite,
        input logic       link,
        input logic       regdst,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        if (!regwrite) return 5'd0;
        if (link)      return 5'd31;
        return regdst ? rd : rt;
    endfunction

    // Counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        stall = 1'b0;
        if (bus.IF_ID_Valid && !bus.Flush && id_ex_mr && (id_ex_rd != 5'd0)) begin
            if ((id_ex_rd == bus.IF_ID_RegisterRs) ||
                (bus.ID_UsesRt && (id_ex_rd == bus.IF_ID_RegisterRt))) begin
                stall = 1'b1;
            end
        end
    end

    // A flushed, stalled or empty decode slot enters EX as an all-zero bubble;
    // the stalled instruction itself stays in IF/ID and is re-presented.
    assign bubble   = bus.Flush || stall || !bus.IF_ID_Valid;
    assign dec_dest = dest_sel(bus.ID_RegWrite, bus.ID_Link, bus.ID_RegDst,
                               bus.IF_ID_RegisterRt, bus.IF_ID_RegisterRd);

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_rs <= 5'd0;
            id_ex_rt <= 5'd0;
            id_ex_rd <= 5'd0;
            id_ex_rw <= 1'b0;
            id_ex_mr <= 1'b0;
        end else if (bubble) begin
            id_ex_rs <= 5'd0;
            id_ex_rt <= 5'd0;
            id_ex_rd <= 5'd0;
            id_ex_rw <= 1'b0;
            id_ex_mr <= 1'b0;
        end else begin
            id_ex_rs <= bus.IF_ID_RegisterRs;
            id_ex_rt <= bus.IF_ID_RegisterRt;
            id_ex_rd <= dec_dest;
            id_ex_rw <= bus.ID_RegWrite;
            id_ex_mr <= bus.ID_MemRead;
        end
    end

    // ---- EX -> MEM and MEM -> WB boundaries (never frozen by Stall) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_rd <= 5'd0;
            ex_mem_rw <= 1'b0;
            ex_mem_mr <= 1'b0;
            mem_wb_rd <= 5'd0;
            mem_wb_rw <= 1'b0;
        end else begin
            ex_mem_rd <= id_ex_rd;
            ex_mem_rw <= id_ex_rw;
            ex_mem_mr <= id_ex_mr;
            mem_wb_rd <= ex_mem_rd;
            mem_wb_rw <= ex_mem_rw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= sat_inc(stall_count);
        end
    end

    assign bus.ID_EX_RegisterRs  = id_ex_rs;
    assign bus.ID_EX_RegisterRt  = id_ex_rt;
    assign bus.ID_EX_RegisterRd  = id_ex_rd;
    assign bus.ID_EX_RegWrite    = id_ex_rw;
    assign bus.ID_EX_MemRead     = id_ex_mr;
    assign bus.EX_MEM_RegisterRd = ex_mem_rd;
    assign bus.EX_MEM_RegWrite   = ex_mem_rw;
    assign bus.EX_MEM_MemRead    = ex_mem_mr;
    assign bus.MEM_WB_RegisterRd = mem_wb_rd;
    assign bus.MEM_WB_RegWrite   = mem_wb_rw;
    assign bus.Stall             = stall;
    assign bus.StallCount        = stall_count;

endmodule

// File: tb/tb_wb_tag_pipeline.sv
// tb_wb_tag_pipeline
//   Scoreboard bench for wb_tag_pipeline. Two instances share the decode
//   inputs: one with a 16-bit stall counter, one with a 2-bit counter so
//   saturation is exercised. Stimulus pushes the expected outputs for each
//   cycle; a negedge monitor pops and compares.
module tb_wb_tag_pipeline;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_tag_pipeline_if #(.CNT_W(16)) bus ();
    wb_tag_pipeline_if #(.CNT_W(2))  bus_s ();

    assign bus_s.IF_ID_Valid      = bus.IF_ID_Valid;
    assign bus_s.IF_ID_RegisterRs = bus.IF_ID_RegisterRs;
    assign bus_s.IF_ID_RegisterRt = bus.IF_ID_RegisterRt;
    assign bus_s.IF_ID_RegisterRd = bus.IF_ID_RegisterRd;
    assign bus_s.ID_RegWrite      = bus.ID_RegWrite;
    assign bus_s.ID_MemRead       = bus.ID_MemRead;
    assign bus_s.ID_RegDst        = bus.ID_RegDst;
    assign bus_s.ID_Link          = bus.ID_Link;
    assign bus_s.ID_UsesRt        = bus.ID_UsesRt;
    assign bus_s.Flush            = bus.Flush;

    wb_tag_pipeline #(.CNT_W(16)) dut   (.clk(clk), .reset(rst), .bus(bus));
    wb_tag_pipeline #(.CNT_W(2))  dut_s (.clk(clk), .reset(rst), .bus(bus_s));

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } rec_t;

    typedef struct {
        logic stall;
        rec_t ex;
        rec_t mem;
        rec_t wb;
        int   c16;
        int   c2;
    } exp_t;

    // Reference model: an instruction history list, index 0 = EX, 1 = MEM, 2 = WB.
    rec_t pipe [3];
    rec_t empty_rec = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    int   cnt16 = 0;
    int   cnt2  = 0;
    exp_t sb [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            me = sb.pop_front();
            chk("Stall",             int'(bus.Stall),             int'(me.stall));
            chk("Stall_cnt2",        int'(bus_s.Stall),           int'(me.stall));
            chk("ID_EX_RegisterRs",  int'(bus.ID_EX_RegisterRs),  int'(me.ex.rs));
            chk("ID_EX_RegisterRt",  int'(bus.ID_EX_RegisterRt),  int'(me.ex.rt));
            chk("ID_EX_RegisterRd",  int'(bus.ID_EX_RegisterRd),  int'(me.ex.rd));
            chk("ID_EX_RegWrite",    int'(bus.ID_EX_RegWrite),    int'(me.ex.rw));
            chk("ID_EX_MemRead",     int'(bus.ID_EX_MemRead),     int'(me.ex.mr));
            chk("EX_MEM_RegisterRd", int'(bus.EX_MEM_RegisterRd), int'(me.mem.rd));
            chk("EX_MEM_RegWrite",   int'(bus.EX_MEM_RegWrite),   int'(me.mem.rw));
            chk("EX_MEM_MemRead",    int'(bus.EX_MEM_MemRead),    int'(me.mem.mr));
            chk("MEM_WB_RegisterRd", int'(bus.MEM_WB_RegisterRd), int'(me.wb.rd));
            chk("MEM_WB_RegWrite",   int'(bus.MEM_WB_RegWrite),   int'(me.wb.rw));
            chk("StallCount16",      int'(bus.StallCount),        me.c16);
            chk("StallCount2",       int'(bus_s.StallCount),      me.c2);
        end
    end

    // One clock of stimulus: drive inputs, record what the outputs must be
    // this cycle, then advance the model across the coming edge.
    task automatic step(input logic r, input logic v,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic rdst,
                        input logic lnk, input logic urt, input logic fl,
                        output logic stalled);
        exp_t e;
        rec_t nr;
        logic s;
        logic [4:0] dest;
        rst                  = r;
        bus.IF_ID_Valid      = v;
        bus.IF_ID_RegisterRs = rs;
        bus.IF_ID_RegisterRt = rt;
        bus.IF_ID_RegisterRd = rd;
        bus.ID_RegWrite      = rw;
        bus.ID_MemRead       = mr;
        bus.ID_RegDst        = rdst;
        bus.ID_Link          = lnk;
        bus.ID_UsesRt        = urt;
        bus.Flush            = fl;

        // A load sitting in EX whose (nonzero) destination is read here.
        s = v && !fl && pipe[0].mr && pipe[0].rd != 0 &&
            (pipe[0].rd == rs || (urt && pipe[0].rd == rt));

        e.stall = s;
        e.ex    = pipe[0];
        e.mem   = pipe[1];
        e.wb    = pipe[2];
        e.c16   = cnt16;
        e.c2    = cnt2;
        sb.push_back(e);

        if (r) begin
            pipe[0] = empty_rec;
            pipe[1] = empty_rec;
            pipe[2] = empty_rec;
            cnt16   = 0;
            cnt2    = 0;
        end else begin
            nr = empty_rec;
            if (v && !fl && !s) begin
                if (!rw)      dest = 5'd0;
                else if (lnk) dest = 5'd31;
                else          dest = rdst ? rd : rt;
                nr = '{rs, rt, dest, rw, mr};
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nr;
            if (s) begin
                cnt16 = (cnt16 < 65535) ? cnt16 + 1 : 65535;
                cnt2  = (cnt2 < 3) ? cnt2 + 1 : 3;
            end
        end
        stalled = s;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    logic       st;
    logic       hold;
    logic [4:0] r_rs, r_rt, r_rd;
    logic       r_v, r_rw, r_mr, r_dst, r_lnk, r_urt, r_fl, r_rst;

    initial begin
        pipe[0] = empty_rec;
        pipe[1] = empty_rec;
        pipe[2] = empty_rec;
        rst = 1'b1;
        bus.IF_ID_Valid = 0; bus.IF_ID_RegisterRs = 0; bus.IF_ID_RegisterRt = 0;
        bus.IF_ID_RegisterRd = 0; bus.ID_RegWrite = 0; bus.ID_MemRead = 0;
        bus.ID_RegDst = 0; bus.ID_Link = 0; bus.ID_UsesRt = 0; bus.Flush = 0;
        @(posedge clk);
        #1;

        // Reset held 2 cycles with random decode inputs.
        for (int i = 0; i < 2; i++)
            step(1, 1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 0, st);

        // add $3,$1,$2 then NOPs.
        step(0, 1, 1, 2, 3, 1, 0, 1, 0, 1, 0, st);
        nop(4);

        // lw $4,0($1) ; sub $5,$4,$6 (stalls once, then re-presented).
        step(0, 1, 1, 4, 0, 1, 1, 0, 0, 0, 0, st);
        step(0, 1, 4, 6, 5, 1, 0, 1, 0, 1, 0, st);
        step(0, 1, 4, 6, 5, 1, 0, 1, 0, 1, 0, st);
        nop(3);

        // lw $4 ; sw $4,0($1): rt is a source.
        step(0, 1, 1, 4, 0, 1, 1, 0, 0, 0, 0, st);
        step(0, 1, 1, 4, 0, 0, 0, 0, 0, 1, 0, st);
        step(0, 1, 1, 4, 0, 0, 0, 0, 0, 1, 0, st);
        nop(2);

        // lw $4 ; instruction with rt=4 that does not read rt.
        step(0, 1, 1, 4, 0, 1, 1, 0, 0, 0, 0, st);
        step(0, 1, 1, 4, 7, 1, 0, 1, 0, 0, 0, st);
        nop(2);

        // lw $0 ; add $5,$0,$0.
        step(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, st);
        step(0, 1, 0, 0, 5, 1, 0, 1, 0, 1, 0, st);
        nop(2);

        // Load-use pair with Flush in the would-be stall cycle.
        step(0, 1, 1, 4, 0, 1, 1, 0, 0, 0, 0, st);
        step(0, 1, 4, 6, 5, 1, 0, 1, 0, 1, 1, st);
        nop(2);

        // jal: destination $31 regardless of RegDst.
        step(0, 1, 0, 9, 8, 1, 0, 1, 1, 0, 0, st);
        nop(3);

        // Saturation: fresh reset, then 5 load-use pairs.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 2, 4, 0, 1, 1, 0, 0, 0, 0, st);
            step(0, 1, 4, 4, 5, 1, 0, 1, 0, 1, 0, st);
            step(0, 1, 4, 4, 5, 1, 0, 1, 0, 1, 0, st);
            nop(1);
        end

        // Random traffic; a stalled instruction is re-presented unchanged.
        hold = 0;
        r_v = 0; r_rs = 0; r_rt = 0; r_rd = 0; r_rw = 0; r_mr = 0;
        r_dst = 0; r_lnk = 0; r_urt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                r_v   = ($urandom_range(0, 9) != 0);
                r_rs  = 5'($urandom_range(0, 7));
                r_rt  = 5'($urandom_range(0, 7));
                r_rd  = 5'($urandom_range(0, 7));
                r_mr  = ($urandom_range(0, 9) < 4);
                r_rw  = r_mr ? 1'b1 : 1'($urandom);
                r_dst = 1'($urandom);
                r_lnk = ($urandom_range(0, 9) == 0);
                r_urt = 1'($urandom);
            end
            r_fl  = ($urandom_range(0, 9) == 0);
            r_rst = ($urandom_range(0, 199) == 0);
            step(r_rst, r_v, r_rs, r_rt, r_rd, r_rw, r_mr, r_dst, r_lnk, r_urt, r_fl, st);
            hold = st;
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_tag_pipeline.md
# wb_tag_pipeline

Destination-tag pipeline and load-use hazard detector for the five-stage MIPS CPU. The block owns the register-write bookkeeping that the forwarding logic consumes. It latches each decoded instruction's source and destination register numbers into ID/EX, carries the destination tag through EX/MEM and MEM/WB, and raises a stall when a load's result is needed by the next instruction. Every ID/EX, EX/MEM and MEM/WB tag output of this block connects directly to the forwarding unit's inputs.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- IF_ID_Valid  in  1  IF/ID holds a real instruction
- IF_ID_RegisterRs  in  5  rs field of the instruction in decode
- IF_ID_RegisterRt  in  5  rt field of the instruction in decode
- IF_ID_RegisterRd  in  5  rd field of the instruction in decode
- ID_RegWrite  in  1  decoded instruction writes the register file
- ID_MemRead  in  1  decoded instruction is a load
- ID_RegDst  in  1  1: destination is rd; 0: destination is rt
- ID_Link  in  1  jal-type instruction; destination is $31 (overrides RegDst)
- ID_UsesRt  in  1  decoded instruction reads rt as a source
- Flush  in  1  squash the instruction in decode (taken branch/jump)
- ID_EX_RegisterRs, ID_EX_RegisterRt  out  5 each  source tags in EX
- ID_EX_RegWrite, ID_EX_MemRead  out  1 each  control bits in EX
- ID_EX_RegisterRd  out  5  destination tag in EX
- EX_MEM_RegWrite, EX_MEM_MemRead  out  1 each  control bits in MEM
- EX_MEM_RegisterRd  out  5  destination tag in MEM
- MEM_WB_RegWrite  out  1  write-enable in WB
- MEM_WB_RegisterRd  out  5  destination tag in WB
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- StallCount  out  CNT_W  number of stall cycles since reset, saturating

## Operation
- Destination select: dest = ID_Link ? 5'd31 : (ID_RegDst ? IF_ID_RegisterRd : IF_ID_RegisterRt).
- Stored dest is forced to 0 when ID_RegWrite=0. Downstream logic can therefore treat Rd==0 as "no write".
- Load-use stall: Stall = IF_ID_Valid & ~Flush & ID_EX_MemRead & (ID_EX_RegisterRd != 0) & ((ID_EX_RegisterRd == IF_ID_RegisterRs) | (ID_UsesRt & (ID_EX_RegisterRd == IF_ID_RegisterRt))).
- ID/EX load, in priority order:
  - reset: all fields 0.
  - Flush, Stall, or ~IF_ID_Valid: bubble, all fields 0.
  - Otherwise: decoded fields are captured.
- EX/MEM ← ID/EX and MEM/WB ← EX/MEM every cycle, unconditionally. Stall never freezes the back end.
- StallCount increments on each rising edge where Stall=1. It holds at 2^CNT_W−1 and does not wrap.
- Flush and a would-be stall in the same cycle: Flush wins, Stall=0, bubble inserted, count unchanged.
- A stalled instruction is re-presented next cycle. The bubble now sits in ID/EX (MemRead=0), so Stall deasserts and the instruction proceeds. The load value reaches it via MEM/WB forwarding.
- Register $0 never produces a stall or a nonzero write tag.

## Timing
- Reset: every output register is 0, including StallCount. Stall is therefore 0 immediately after reset.
- Latency: an instruction decoded in cycle n appears on ID_EX_* at n+1, EX_MEM_* at n+2, and MEM_WB_* at n+3.
- A stall lasts exactly one cycle per load-use pair. Back-to-back load-use pairs each cost one cycle.
- Reset asserted mid-stream clears all three stages on that edge. In-flight tags are discarded, not drained.
- Stall is a pure function of the current inputs and ID/EX state. It has no registered delay.

## Test plan
- Reset: hold reset 2 cycles with random inputs → all outputs 0, Stall=0, StallCount=0.
- Pipeline:
  - Stimulus: `add $3,$1,$2` (RegWrite=1, RegDst=1, Rd=3) then NOPs.
  - Response: ID_EX_RegisterRd=3 at n+1, EX_MEM_RegisterRd=3 at n+2, MEM_WB_RegisterRd=3 with MEM_WB_RegWrite=1 at n+3, then all 0.
- Load-use:
  - Stimulus: `lw $4,0($1)` followed by `sub $5,$4,$6`.
  - Response: Stall=1 for exactly one cycle, ID/EX holds a bubble, sub enters ID/EX one cycle later, StallCount=1.
- Rt and $0 rules:
  - Stimulus 1: `lw $4` then `sw $4` → Stall=1 when ID_UsesRt=1, and Stall=0 when ID_UsesRt=0 with rt=4.
  - Stimulus 2: `lw $0` then `add` using $0 → Stall=0, ID_EX_RegisterRd=0.
- Flush priority and link:
  - Stimulus 1: load-use pair with Flush=1 in the stall cycle → Stall=0, bubble in ID/EX, StallCount unchanged.
  - Stimulus 2: jal (ID_Link=1) → ID_EX_RegisterRd=31.
- Saturation: set CNT_W=2 and run 5 load-use pairs → StallCount reads 1, 2, 3, 3, 3.
